// File: rtl/nios_color_out_pkg.sv
// Shared register map and STATUS bit positions for the colour output peripheral.
package nios_color_out_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_LVL_LSB = 4;

endpackage

// File: rtl/color_out_fifo.sv
// Synchronous FIFO for colour words; power-of-two depth so pointers wrap naturally.
// A push while full is only taken when a pop frees the head on the same edge.
module color_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nios_system_color_out.sv
// Avalon-MM colour output PIO: register decode, overflow flag, out_port and readdata.
// Define COLOR_OUT_BITSET_EN to enable the OUTSET/OUTCLEAR registers and their shadow.
module nios_system_color_out
    import nios_color_out_pkg::*;
#(
    parameter int               DATA_W      = 16,
    parameter int               FIFO_DEPTH  = 4,
    parameter logic [DATA_W-1:0] RESET_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_port
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              wr;
    logic              push_req;
    logic              push_ok;
    logic [DATA_W-1:0] push_val;
    logic              pop;
    logic              ovf_clr;
    logic              overflow;
    logic              fifo_empty;
    logic              fifo_full;
    logic [LVL_W-1:0]  level;
    logic [31:0]       status;
    logic [31:0]       rd_next;
    logic              unused_wd;

    assign unused_wd = ^writedata;
    assign wr        = chipselect & ~write_n;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_req & (~fifo_full | pop);

`ifdef COLOR_OUT_BITSET_EN
    logic [DATA_W-1:0] shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     shadow <= RESET_COLOR;
        else if (push_ok) shadow <= push_val;
    end
`endif

    always_comb begin
        push_req = 1'b0;
        push_val = writedata[DATA_W-1:0];
        ovf_clr  = 1'b0;
        if (wr) begin
            case (address)
                ADDR_DATA:     push_req = 1'b1;
                ADDR_STATUS:   ovf_clr  = writedata[STAT_OVF];
`ifdef COLOR_OUT_BITSET_EN
                ADDR_OUTSET: begin
                    push_req = 1'b1;
                    push_val = shadow | writedata[DATA_W-1:0];
                end
                ADDR_OUTCLEAR: begin
                    push_req = 1'b1;
                    push_val = shadow & ~writedata[DATA_W-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

    color_out_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (push_val),
        .pop       (pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    // Dropped push sets overflow; a set always beats a clear-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           overflow <= 1'b0;
        else if (push_req & fifo_full & ~pop)   overflow <= 1'b1;
        else if (ovf_clr)                       overflow <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_port <= RESET_COLOR;
        else if (pop) out_port <= out_data;
    end

    always_comb begin
        status                           = '0;
        status[STAT_EMPTY]               = fifo_empty;
        status[STAT_FULL]                = fifo_full;
        status[STAT_OVF]                 = overflow;
        status[STAT_LVL_LSB +: LVL_W]    = level;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:   rd_next = 32'(out_port);
            ADDR_STATUS: rd_next = status;
`ifdef COLOR_OUT_BITSET_EN
            ADDR_OUTSET: rd_next = 32'(shadow);
`endif
            default:     rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

endmodule

// File: tb/tb_nios_system_color_out.sv
// Self-checking bench: directed test-plan sequences plus random traffic against a queue model.
module tb_nios_system_color_out;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_port;

    int total = 0;
    int bad   = 0;

    logic [15:0] q[$];
    logic [15:0] m_port;
    logic [15:0] m_shadow;
    bit          m_ovf;
    logic [31:0] m_rd;

    always #5 clk = ~clk;

    nios_system_color_out #(
        .DATA_W      (16),
        .FIFO_DEPTH  (DEPTH),
        .RESET_COLOR (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_port   = 16'h0000;
        m_shadow = 16'h0000;
        m_ovf    = 1'b0;
        m_rd     = '0;
    endtask

    task automatic drive(input bit cs, input bit wn, input logic [1:0] a,
                         input logic [31:0] wd, input bit rdy);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        out_ready  = rdy;
    endtask

    // Compare DUT against the model, then advance both by one clock.
    task automatic tick();
        logic [31:0] nrd;
        logic [15:0] v;
        int          lvl;
        bit          full, pop, wr, req;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
        check("out_port", 32'(out_port), 32'(m_port));
        check("readdata", readdata, m_rd);
        lvl  = q.size();
        full = (lvl == DEPTH);
        pop  = (lvl > 0) && out_ready;
        wr   = chipselect && !write_n;
        nrd  = '0;
        case (address)
            2'd0: nrd = 32'(m_port);
            2'd1: nrd = 32'(lvl) * 16 + 32'(m_ovf) * 4 + 32'(full) * 2 + 32'(lvl == 0);
`ifdef COLOR_OUT_BITSET_EN
            2'd2: nrd = 32'(m_shadow);
`endif
            default: nrd = '0;
        endcase
        req = 1'b0;
        v   = writedata[15:0];
        if (wr) begin
            if (address == 2'd0) req = 1'b1;
`ifdef COLOR_OUT_BITSET_EN
            if (address == 2'd2) begin req = 1'b1; v = m_shadow | writedata[15:0]; end
            if (address == 2'd3) begin req = 1'b1; v = m_shadow & ~writedata[15:0]; end
`endif
        end
        @(posedge clk);
        #1;
        if (pop) m_port = q.pop_front();
        if (req && (!full || pop)) begin
            q.push_back(v);
            m_shadow = v;
        end else if (req) begin
            m_ovf = 1'b1;
        end else if (wr && address == 2'd1 && writedata[2]) begin
            m_ovf = 1'b0;
        end
        m_rd = nrd;
    endtask

    initial begin
        logic [15:0] seen[$];
        int          guard;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_port", 32'(out_port), 32'h0000);
        check("rst_rd", readdata, 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        reset_n = 1'b1;

        // STATUS after reset reads empty only
        drive(0, 1, 2'd1, 0, 0);
        tick();
        tick();
        check("rst_status", readdata, 32'h1);

        // single write, then consume
        drive(1, 0, 2'd0, 32'h0000_F800, 0);
        tick();
        drive(0, 1, 2'd0, 0, 0);
        check("wr_valid", 32'(out_valid), 32'd1);
        check("wr_data", 32'(out_data), 32'hF800);
        drive(0, 1, 2'd0, 0, 1);
        tick();
        check("pop_port", 32'(out_port), 32'hF800);
        check("pop_valid", 32'(out_valid), 32'd0);

        // five writes into depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2'd0, 32'(16'h1000 + i), 0);
            tick();
        end
        drive(0, 1, 2'd1, 0, 0);
        tick();
        tick();
        check("ovf_status", readdata, 32'h46);
        drive(1, 0, 2'd1, 32'h4, 0);
        tick();
        drive(0, 1, 2'd1, 0, 0);
        tick();
        tick();
        check("ovf_clear", readdata, 32'h42);

        // full and draining: concurrent push accepted, level held
        drive(1, 0, 2'd0, 32'h0000_2222, 1);
        tick();
        drive(0, 1, 2'd1, 0, 0);
        tick();
        tick();
        check("full_push_lvl", readdata, 32'h42);
        seen.delete();
        drive(0, 1, 2'd0, 0, 1);
        guard = 0;
        while (out_valid && guard < 20) begin
            seen.push_back(out_data);
            tick();
            guard++;
        end
        check("drain_bound", 32'(guard), 32'd4);
        if (seen.size() == 4) begin
            check("drain0", 32'(seen[0]), 32'h1001);
            check("drain3", 32'(seen[3]), 32'h2222);
        end

        // bit set / clear registers
        drive(1, 0, 2'd0, 32'h0F0F, 0); tick();
        drive(1, 0, 2'd2, 32'hF000, 0); tick();
        drive(1, 0, 2'd3, 32'h000F, 0); tick();
        drive(0, 1, 2'd2, 0, 0); tick(); tick();
`ifdef COLOR_OUT_BITSET_EN
        check("outset_rd", readdata, 32'hFF00);
        check("bitset_lvl", 32'(q.size()), 32'd3);
`else
        check("outset_rd", readdata, 32'h0);
        check("bitset_lvl", 32'(q.size()), 32'd1);
`endif
        seen.delete();
        drive(0, 1, 2'd0, 0, 1);
        guard = 0;
        while (out_valid && guard < 20) begin
            seen.push_back(out_data);
            tick();
            guard++;
        end
        if (seen.size() > 0) check("bitset0", 32'(seen[0]), 32'h0F0F);
`ifdef COLOR_OUT_BITSET_EN
        check("bitset_cnt", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("bitset1", 32'(seen[1]), 32'hFF0F);
            check("bitset2", 32'(seen[2]), 32'hFF00);
        end
`else
        check("bitset_cnt", 32'(seen.size()), 32'd1);
`endif

        // reset mid-drain with entries queued
        drive(1, 0, 2'd0, 32'hAAAA, 0); tick();
        drive(1, 0, 2'd0, 32'hBBBB, 0); tick();
        drive(1, 0, 2'd0, 32'hCCCC, 0); tick();
        drive(0, 1, 2'd0, 0, 1); tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_port", 32'(out_port), 32'h0000);
        check("midrst_rd", readdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_port", 32'(out_port), 32'h0000);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  2'($urandom_range(0, 3)), $urandom,
                  (i % 300) < 150 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_color_out.md
# nios_system_color_out

Avalon-MM slave output peripheral that carries 16-bit colour words from the Nios II processor to the pixel-drawing datapath. Processor writes are buffered in a small synchronous FIFO and presented on a valid/ready stream. The most recently consumed colour is held on a level output, out_port, for static consumers. It pairs with the existing colour input PIO: that block returns colour to software, this one drives colour from software.

## Interface
- DATA_W, 16, colour word width (≤ 32)
- FIFO_DEPTH, 4, buffer entries; power of two, ≥ 2
- RESET_COLOR, 16'h0000, reset value of out_port and of the shadow register
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write = chipselect & ~write_n
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_data  out  DATA_W  FIFO head colour
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts head
- out_port  out  DATA_W  last colour accepted by downstream

## Operation
- Register map, by address:
  - 0 DATA: write pushes writedata[DATA_W-1:0] and loads shadow. Read returns out_port, zero-extended.
  - 1 STATUS: read returns bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] level, other bits 0. Writing 1 to bit2 clears overflow; other bits are ignored.
  - 2 OUTSET: write pushes shadow | writedata and loads shadow with the same value. Read returns shadow.
  - 3 OUTCLEAR: write pushes shadow & ~writedata and loads shadow with the same value. Read returns 0.
- Push and pop rules:
  - A push into a full FIFO is dropped, sets overflow, and leaves shadow unchanged.
  - Pop occurs when out_valid & out_ready. On the same edge, out_port <= out_data.
  - Simultaneous push and pop while full: the push is accepted and the level is unchanged.
  - Simultaneous push and pop while empty: no pop occurs, because out_valid is low; the push lands and out_valid rises next cycle.
- Arithmetic and pointers:
  - Pointers wrap modulo FIFO_DEPTH.
  - Level is a log2(FIFO_DEPTH)+1 bit count, saturating at FIFO_DEPTH.
- Overflow set and a clear-write in the same cycle: set wins.
- readdata is loaded every cycle from the current address, independent of chipselect, with no wait states.
- Reset, including reset mid-transfer:
  - FIFO emptied, out_valid 0, overflow 0.
  - out_port and shadow = RESET_COLOR.
  - readdata 0, out_data 0.
  - Entries in flight are discarded.

## Timing
- Write to visibility: a write sampled at edge N gives out_valid = 1 and out_data = written value after edge N, in the following cycle (1-cycle latency).
- Read latency: address presented in cycle N gives readdata valid after edge N+1, i.e. 1 cycle.
- out_data and out_valid are combinational from FIFO state only. There is no combinational path from out_ready to out_valid.
- Throughput: one push and one pop per cycle are sustained.
- Back-to-back OUTSET/OUTCLEAR writes each see the shadow value updated by the previous write.

## Configuration
- COLOR_OUT_BITSET_EN, when defined: addresses 2 and 3 behave as specified above.
- When not defined:
  - Writes to addresses 2 and 3 are ignored: no push, no shadow update.
  - Reads of addresses 2 and 3 return 0.
  - The shadow register is optimised away.

## Structure
- Package nios_color_out_pkg holds:
  - register address constants ADDR_DATA, ADDR_STATUS, ADDR_OUTSET, ADDR_OUTCLEAR
  - STATUS bit-position constants
- Sub-module color_out_fifo: parameterised synchronous FIFO.
  - Ports: push, push_data, pop, head, empty, full, level.
  - The top level holds register decode, shadow, overflow, out_port and readdata.

## Test plan
- Reset → out_port = RESET_COLOR, out_valid = 0, readdata 0; STATUS read = 0x1.
- With out_ready = 0: write DATA 0xF800 → out_valid = 1 next cycle, out_data = 0xF800; raise out_ready → out_port = 0xF800 after that edge, out_valid = 0.
- With out_ready = 0: five DATA writes (FIFO_DEPTH 4) → STATUS = 0x46 (level 4, full, overflow); fifth value never appears; write STATUS 0x4 → overflow cleared.
- With full FIFO and out_ready = 1: write in the same cycle → push accepted, level stays 4, order preserved on drain.
- COLOR_OUT_BITSET_EN defined: DATA 0x0F0F, OUTSET 0xF000, OUTCLEAR 0x000F → stream 0x0F0F, 0xFF0F, 0xFF00; OUTSET read returns 0xFF00. Without the macro: only 0x0F0F is emitted and address 2 reads 0.
- Assert reset_n mid-drain with two entries queued → out_valid drops immediately, out_port = RESET_COLOR, no entry emitted after release.
